// File: rtl/m68k_bus_responder_if.sv
// m68k_bus_responder_if -- 68010-side bus bundle for m68k_bus_responder.
//   Strobes  : P_AS_n, P_UDS_n, P_LDS_n, P_RW_n (high = read)
//   Address  : P_A (A23..A1), P_FC (function code)
//   Data     : P_D_in (master -> responder), P_D_out/P_D_oe (responder -> master;
//              the top level builds the tristate)
//   Response : P_DTACK_n, P_BERR_n (active low)
// modport slave  : the responder side.
// modport master : the CPU / bench side.
interface m68k_bus_responder_if;
  logic        P_AS_n;
  logic        P_UDS_n;
  logic        P_LDS_n;
  logic        P_RW_n;
  logic [23:1] P_A;
  logic [2:0]  P_FC;
  logic [15:0] P_D_in;
  logic [15:0] P_D_out;
  logic        P_D_oe;
  logic        P_DTACK_n;
  logic        P_BERR_n;

  modport slave (
    input  P_AS_n, P_UDS_n, P_LDS_n, P_RW_n, P_A, P_FC, P_D_in,
    output P_D_out, P_D_oe, P_DTACK_n, P_BERR_n
  );

  modport master (
    output P_AS_n, P_UDS_n, P_LDS_n, P_RW_n, P_A, P_FC, P_D_in,
    input  P_D_out, P_D_oe, P_DTACK_n, P_BERR_n
  );
endinterface

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder -- asynchronous 68010 bus slave bridging to a simple
// request/acknowledge backing store.
//   C100      : sole clock, rising edge
//   reset     : asynchronous, active high
//   bus       : m68k_bus_responder_if.slave (strobes, address, FC, data, DTACK/BERR)
//   mem_req   : high exactly while a backing-store request is outstanding
//   mem_we/mem_addr/mem_be/mem_wdata : request attributes, captured at cycle start
//   mem_rdata/mem_ack : backing-store completion
// Parameters: BASE_ADDR/ADDR_MASK select the decoded window,
//   TIMEOUT (1..255) is the mem_ack wait before bus error.
// Optional feature: define M68K_RESP_BERR_TIMEOUT_EN to enable the bus-error
//   timeout; without it a request waits indefinitely and P_BERR_n stays high.
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [23:0] ADDR_MASK = 24'hF00000,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                        C100,
  input  logic                        reset,
  m68k_bus_responder_if.slave         bus,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [22:0]                 mem_addr,
  output logic [1:0]                  mem_be,
  output logic [15:0]                 mem_wdata,
  input  logic [15:0]                 mem_rdata,
  input  logic                        mem_ack
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("m68k_bus_responder: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, ACK, ERR} state_t;
  state_t state, state_nxt;

  logic [1:0] as_sync, uds_sync, lds_sync;
  logic [1:0] sync_fill;
  logic       as_s, uds_s, lds_s;
  logic       armed;
  logic       addr_hit;
  logic       start;
  logic       tmo_hit;

  assign as_s  = as_sync[1];
  assign uds_s = uds_sync[1];
  assign lds_s = lds_sync[1];

  always_ff @(posedge C100 or posedge reset) begin
    if (reset) begin
      as_sync   <= '1;
      uds_sync  <= '1;
      lds_sync  <= '1;
      sync_fill <= '0;
    end else begin
      as_sync   <= {as_sync[0],  bus.P_AS_n};
      uds_sync  <= {uds_sync[0], bus.P_UDS_n};
      lds_sync  <= {lds_sync[0], bus.P_LDS_n};
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  assign addr_hit = (({bus.P_A, 1'b0} & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign start    = (state == IDLE) && !as_s && (!uds_s || !lds_s) && armed && addr_hit;

  // The synchronizers reset to 1, so as_s reads "negated" for two edges after
  // reset regardless of the pin. Arming waits for sync_fill so that only a
  // genuinely sampled AS_n high can re-arm after a mid-cycle reset.
  always_ff @(posedge C100 or posedge reset) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (start) begin
      armed <= 1'b0;
    end else if (state == IDLE && as_s && sync_fill[1]) begin
      armed <= 1'b1;
    end
  end

`ifdef M68K_RESP_BERR_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt;

  always_ff @(posedge C100 or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (start) begin
      tmo_cnt <= '0;
    end else if (state == REQ) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // Count value TIMEOUT-1 on the current edge means this edge is the
  // TIMEOUT-th REQ cycle.
  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge C100 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort beats mem_ack, and mem_ack beats the timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (as_s)         state_nxt = IDLE;
        else if (mem_ack) state_nxt = ACK;
        else if (tmo_hit) state_nxt = ERR;
      end
      ACK:  if (as_s) state_nxt = IDLE;
      ERR:  if (as_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req       = (state == REQ);
    bus.P_DTACK_n = (state != ACK);
    bus.P_D_oe    = (state == ACK) && !mem_we;
`ifdef M68K_RESP_BERR_TIMEOUT_EN
    bus.P_BERR_n  = (state != ERR);
`else
    bus.P_BERR_n  = 1'b1;
`endif
  end

  always_ff @(posedge C100 or posedge reset) begin
    if (reset) begin
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      bus.P_D_out <= '0;
    end else begin
      if (start) begin
        mem_addr  <= bus.P_A;
        mem_we    <= ~bus.P_RW_n;
        mem_wdata <= bus.P_D_in;
        mem_be    <= ~{uds_s, lds_s};
      end
      if (state == REQ && !as_s && mem_ack && !mem_we) begin
        bus.P_D_out <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
module tb_m68k_bus_responder;
  localparam int unsigned TMO  = 4;
  localparam logic [23:0] BASE = 24'h000000;
  localparam logic [23:0] MASK = 24'hF00000;

  logic        C100 = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  m68k_bus_responder_if bus();

  m68k_bus_responder #(.BASE_ADDR(BASE), .ADDR_MASK(MASK), .TIMEOUT(TMO)) dut (
    .C100(C100), .reset(reset), .bus(bus.slave),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 C100 = ~C100;

  typedef struct {
    bit          got_req;
    int          req_lat;
    logic [22:0] maddr;
    logic        mwe;
    logic [1:0]  mbe;
    logic [15:0] mwdata;
    bit          stable;
    logic        dtack_ack;
    logic [15:0] dout;
    logic        doe;
    bit          held;
    int          rel_lat;
    bit          quiet;
  } obs_t;

  typedef struct {
    bit          hit;
    logic [22:0] maddr;
    logic        mwe;
    logic [1:0]  mbe;
    logic [15:0] mwdata;
    logic        doe;
  } exp_t;

  // Expected request attributes derived straight from the bus-cycle description.
  function automatic exp_t model(logic [23:0] addr, bit rd, bit u, bit l, logic [15:0] wd);
    exp_t m;
    m.hit    = ((addr & MASK) == (BASE & MASK));
    m.maddr  = addr[23:1];
    m.mwe    = !rd;
    m.mbe    = {u, l};
    m.mwdata = wd;
    m.doe    = rd;
    return m;
  endfunction

  // Plays the CPU and the backing store for one bus cycle; records observations only.
  task automatic run_cycle(input logic [23:0] addr, input bit rd, input bit u, input bit l,
                           input logic [15:0] wd, input int sdly, input int ack_dly,
                           input logic [15:0] rdat, output obs_t o);
    o = '{default: 0};
    @(negedge C100);
    bus.P_A = addr[23:1]; bus.P_RW_n = rd; bus.P_FC = 3'b101; bus.P_D_in = wd;
    bus.P_AS_n = 1'b0;
    repeat (sdly) @(negedge C100);
    bus.P_UDS_n = !u; bus.P_LDS_n = !l;
    o.quiet = 1;
    for (int k = 1; k <= 8 && !o.got_req; k++) begin
      @(negedge C100);
      if (mem_req === 1'b1) begin
        o.got_req = 1; o.req_lat = k;
      end else if (bus.P_DTACK_n !== 1'b1 || bus.P_BERR_n !== 1'b1 || bus.P_D_oe !== 1'b0) begin
        o.quiet = 0;
      end
    end
    if (o.got_req) begin
      o.maddr = mem_addr; o.mwe = mem_we; o.mbe = mem_be; o.mwdata = mem_wdata;
      bus.P_D_in = ~wd;
      o.stable = 1;
      repeat (ack_dly) begin
        @(negedge C100);
        if (mem_req !== 1'b1 || mem_addr !== o.maddr || mem_we !== o.mwe ||
            mem_be !== o.mbe || mem_wdata !== o.mwdata) o.stable = 0;
      end
      mem_rdata = rdat; mem_ack = 1'b1;
      @(negedge C100);
      mem_ack = 1'b0; mem_rdata = 16'($urandom);
      o.dtack_ack = bus.P_DTACK_n; o.dout = bus.P_D_out; o.doe = bus.P_D_oe;
      if (mem_req !== 1'b0) o.stable = 0;
      o.held = 1;
      repeat (2) begin
        @(negedge C100);
        if (bus.P_DTACK_n !== 1'b0 || mem_req !== 1'b0) o.held = 0;
      end
    end
    bus.P_AS_n = 1'b1; bus.P_UDS_n = 1'b1; bus.P_LDS_n = 1'b1;
    if (o.got_req) begin
      for (int k = 1; k <= 10 && o.rel_lat == 0; k++) begin
        @(negedge C100);
        if (bus.P_DTACK_n === 1'b1 && bus.P_D_oe === 1'b0) o.rel_lat = k;
      end
    end
    repeat (3 + $urandom_range(0, 2)) @(negedge C100);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge C100);
    checks++;
    if ({mem_req, mem_we, mem_be} !== 4'b0000) begin
      errors++; $display("FAIL reset_req_we_be got %b exp 0000", {mem_req, mem_we, mem_be});
    end
    checks++;
    if ({mem_addr, mem_wdata, bus.P_D_out} !== 55'd0) begin
      errors++; $display("FAIL reset_data got %h/%h/%h exp 0", mem_addr, mem_wdata, bus.P_D_out);
    end
    checks++;
    if ({bus.P_D_oe, bus.P_DTACK_n, bus.P_BERR_n} !== 3'b011) begin
      errors++; $display("FAIL reset_bus got %b exp 011", {bus.P_D_oe, bus.P_DTACK_n, bus.P_BERR_n});
    end
    reset = 1'b0;
    repeat (4) @(negedge C100);
  endtask

  task automatic test_read_fixed();
    obs_t o;
    run_cycle(24'h000100, 1, 1, 1, 16'h0000, 0, 2, 16'hBEEF, o);
    checks++;
    if (o.got_req !== 1 || o.req_lat !== 3) begin
      errors++; $display("FAIL read_req_latency got %0d/%0d exp 1/3", o.got_req, o.req_lat);
    end
    checks++;
    if ({o.maddr, o.mwe, o.mbe} !== {23'h000080, 1'b0, 2'b11}) begin
      errors++; $display("FAIL read_attr got %h/%b/%b exp 000080/0/11", o.maddr, o.mwe, o.mbe);
    end
    checks++;
    if (o.dout !== 16'hBEEF || o.doe !== 1'b1 || o.dtack_ack !== 1'b0) begin
      errors++; $display("FAIL read_data got %h oe %b dtack %b exp BEEF 1 0", o.dout, o.doe, o.dtack_ack);
    end
    checks++;
    if (o.stable !== 1 || o.held !== 1 || o.rel_lat !== 3) begin
      errors++; $display("FAIL read_hold got stable %0d held %0d rel %0d exp 1 1 3", o.stable, o.held, o.rel_lat);
    end
  endtask

  task automatic test_byte_write();
    obs_t o;
    run_cycle(24'h000201, 0, 0, 1, 16'h12AB, 1, 1, 16'h5555, o);
    checks++;
    if (o.got_req !== 1 || o.req_lat !== 3) begin
      errors++; $display("FAIL bwr_req_latency got %0d/%0d exp 1/3", o.got_req, o.req_lat);
    end
    checks++;
    if ({o.maddr, o.mwe, o.mbe, o.mwdata} !== {23'h000100, 1'b1, 2'b01, 16'h12AB}) begin
      errors++; $display("FAIL bwr_attr got %h/%b/%b/%h exp 000100/1/01/12AB", o.maddr, o.mwe, o.mbe, o.mwdata);
    end
    checks++;
    if (o.doe !== 1'b0 || o.dtack_ack !== 1'b0 || o.stable !== 1) begin
      errors++; $display("FAIL bwr_resp got oe %b dtack %b stable %0d exp 0 0 1", o.doe, o.dtack_ack, o.stable);
    end
  endtask

  task automatic test_nonmatch();
    obs_t o;
    logic [23:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 24'h400000 : {4'($urandom_range(1, 15)), 20'($urandom)};
      run_cycle(a, i[0], 1, 1, 16'($urandom), 0, 0, 16'h0, o);
      checks++;
      if (o.got_req !== 0 || o.quiet !== 1) begin
        errors++; $display("FAIL nomatch_%h got req %0d quiet %0d exp 0 1", a, o.got_req, o.quiet);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic [23:0] a;
    logic [15:0] wd, rdat;
    bit rd, u, l;
    int sel;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 3) != 0) ? {4'h0, 20'($urandom)} : {4'($urandom_range(1, 15)), 20'($urandom)};
      rd = bit'($urandom_range(0, 1));
      sel = $urandom_range(0, 2);
      u = (sel != 2); l = (sel != 1);
      wd = 16'($urandom); rdat = 16'($urandom);
      run_cycle(a, rd, u, l, wd, $urandom_range(0, 2), $urandom_range(0, 2), rdat, o);
      e = model(a, rd, u, l, wd);
      checks++;
      if (o.got_req !== e.hit) begin
        errors++; $display("FAIL rnd%0d_req got %0d exp %0d", i, o.got_req, e.hit);
      end
      if (e.hit) begin
        checks++;
        if (o.req_lat !== 3) begin
          errors++; $display("FAIL rnd%0d_latency got %0d exp 3", i, o.req_lat);
        end
        checks++;
        if ({o.maddr, o.mwe, o.mbe, o.mwdata} !== {e.maddr, e.mwe, e.mbe, e.mwdata}) begin
          errors++; $display("FAIL rnd%0d_attr got %h/%b/%b/%h exp %h/%b/%b/%h", i,
                             o.maddr, o.mwe, o.mbe, o.mwdata, e.maddr, e.mwe, e.mbe, e.mwdata);
        end
        checks++;
        if ({o.dtack_ack, o.doe} !== {1'b0, e.doe} || o.stable !== 1) begin
          errors++; $display("FAIL rnd%0d_resp got dtack %b oe %b stable %0d exp 0 %b 1", i, o.dtack_ack, o.doe, o.stable, e.doe);
        end
        if (rd) begin
          checks++;
          if (o.dout !== rdat) begin
            errors++; $display("FAIL rnd%0d_rdata got %h exp %h", i, o.dout, rdat);
          end
        end
        checks++;
        if (o.held !== 1 || o.rel_lat !== 3) begin
          errors++; $display("FAIL rnd%0d_release got held %0d rel %0d exp 1 3", i, o.held, o.rel_lat);
        end
      end else begin
        checks++;
        if (o.quiet !== 1) begin
          errors++; $display("FAIL rnd%0d_quiet got %0d exp 1", i, o.quiet);
        end
      end
    end
  endtask

  // mem_ack arriving on the TIMEOUT-th REQ cycle completes the access normally.
  task automatic test_ack_at_timeout();
    obs_t o;
    run_cycle(24'h000300, 1, 1, 1, 16'h0, 0, TMO - 1, 16'hA5C3, o);
    checks++;
    if (o.got_req !== 1 || o.dtack_ack !== 1'b0 || o.dout !== 16'hA5C3) begin
      errors++; $display("FAIL ack_at_limit got req %0d dtack %b data %h exp 1 0 A5C3", o.got_req, o.dtack_ack, o.dout);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit berr_ok;
    bit seen;
    @(negedge C100);
    bus.P_A = 23'h000010; bus.P_RW_n = 1'b1; bus.P_AS_n = 1'b0; bus.P_UDS_n = 1'b0; bus.P_LDS_n = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge C100);
      if (mem_req === 1'b1) seen = 1;
    end
    n = 0;
    if (seen) begin
      n = 1;
      for (int k = 0; k < 29 && mem_req === 1'b1; k++) begin
        @(negedge C100);
        if (mem_req === 1'b1) n++;
      end
    end
    berr_ok = 1;
`ifdef M68K_RESP_BERR_TIMEOUT_EN
    checks++;
    if (n !== TMO) begin
      errors++; $display("FAIL tmo_req_cycles got %0d exp %0d", n, TMO);
    end
    repeat (3) begin
      if (bus.P_BERR_n !== 1'b0 || bus.P_DTACK_n !== 1'b1) berr_ok = 0;
      @(negedge C100);
    end
    checks++;
    if (!berr_ok) begin
      errors++; $display("FAIL tmo_berr_hold got berr %b dtack %b exp 0 1", bus.P_BERR_n, bus.P_DTACK_n);
    end
`else
    checks++;
    if (n !== 30) begin
      errors++; $display("FAIL tmo_req_held got %0d exp 30", n);
    end
    checks++;
    if (bus.P_BERR_n !== 1'b1) begin
      errors++; $display("FAIL tmo_berr_idle got %b exp 1", bus.P_BERR_n);
    end
`endif
    bus.P_AS_n = 1'b1; bus.P_UDS_n = 1'b1; bus.P_LDS_n = 1'b1;
    repeat (4) @(negedge C100);
    checks++;
    if (bus.P_BERR_n !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL tmo_release got berr %b req %b exp 1 0", bus.P_BERR_n, mem_req);
    end
    repeat (2) @(negedge C100);
  endtask

  task automatic test_abort();
    obs_t o;
    bit seen, quiet;
    @(negedge C100);
    bus.P_A = 23'h000050; bus.P_RW_n = 1'b1; bus.P_AS_n = 1'b0; bus.P_UDS_n = 1'b0; bus.P_LDS_n = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge C100);
      if (mem_req === 1'b1) seen = 1;
    end
    bus.P_AS_n = 1'b1; bus.P_UDS_n = 1'b1; bus.P_LDS_n = 1'b1;
    repeat (2) @(negedge C100);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge C100);
    mem_ack = 1'b0;
    quiet = 1;
    repeat (4) begin
      if (mem_req !== 1'b0 || bus.P_DTACK_n !== 1'b1 || bus.P_D_oe !== 1'b0) quiet = 0;
      @(negedge C100);
    end
    checks++;
    if (!seen || !quiet) begin
      errors++; $display("FAIL abort_no_dtack got req_seen %0d quiet %0d exp 1 1", seen, quiet);
    end
    run_cycle(24'h000060, 1, 1, 1, 16'h0, 0, 1, 16'h7E57, o);
    checks++;
    if (o.got_req !== 1 || o.dtack_ack !== 1'b0 || o.dout !== 16'h7E57) begin
      errors++; $display("FAIL abort_next got req %0d dtack %b data %h exp 1 0 7E57", o.got_req, o.dtack_ack, o.dout);
    end
  endtask

  task automatic test_reset_midcycle();
    obs_t o;
    bit seen, spurious;
    @(negedge C100);
    bus.P_A = 23'h000070; bus.P_RW_n = 1'b0; bus.P_D_in = 16'h3C3C;
    bus.P_AS_n = 1'b0; bus.P_UDS_n = 1'b0; bus.P_LDS_n = 1'b0;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge C100);
      if (mem_req === 1'b1) seen = 1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if (!seen || mem_req !== 1'b0 || bus.P_DTACK_n !== 1'b1 || bus.P_D_oe !== 1'b0) begin
      errors++; $display("FAIL rst_release got seen %0d req %b dtack %b oe %b exp 1 0 1 0", seen, mem_req, bus.P_DTACK_n, bus.P_D_oe);
    end
    @(negedge C100);
    reset = 1'b0;
    spurious = 0;
    repeat (10) begin
      @(negedge C100);
      if (mem_req !== 1'b0) spurious = 1;
    end
    checks++;
    if (spurious) begin
      errors++; $display("FAIL rst_no_restart got req 1 exp 0");
    end
    bus.P_AS_n = 1'b1; bus.P_UDS_n = 1'b1; bus.P_LDS_n = 1'b1;
    repeat (4) @(negedge C100);
    run_cycle(24'h000070, 0, 1, 1, 16'h3C3C, 0, 0, 16'h0, o);
    checks++;
    if (o.got_req !== 1 || o.dtack_ack !== 1'b0 || o.mwdata !== 16'h3C3C) begin
      errors++; $display("FAIL rst_fresh_cycle got req %0d dtack %b wdata %h exp 1 0 3C3C", o.got_req, o.dtack_ack, o.mwdata);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_cycle(24'h0ABCDE, 0, 1, 1, 16'hCAFE, 0, 0, 16'h0, o1);
    run_cycle(24'h0ABCDE, 1, 1, 1, 16'h0, 0, 0, 16'hF00D, o2);
    checks++;
    if (o1.mwdata !== 16'hCAFE || o1.mwe !== 1'b1 || o1.dtack_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_write got %h we %b dtack %b exp CAFE 1 0", o1.mwdata, o1.mwe, o1.dtack_ack);
    end
    checks++;
    if (o2.dout !== 16'hF00D || o2.doe !== 1'b1 || o2.req_lat !== 3) begin
      errors++; $display("FAIL b2b_read got %h oe %b lat %0d exp F00D 1 3", o2.dout, o2.doe, o2.req_lat);
    end
  endtask

  initial begin
    bus.P_AS_n = 1'b1; bus.P_UDS_n = 1'b1; bus.P_LDS_n = 1'b1; bus.P_RW_n = 1'b1;
    bus.P_A = '0; bus.P_FC = 3'b101; bus.P_D_in = '0;
    test_reset();
    test_read_fixed();
    test_byte_write();
    test_nonmatch();
    test_random();
    test_ack_at_timeout();
    test_timeout();
    test_abort();
    test_reset_midcycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
